// File: rtl/timer_scheduler.sv
// timer_scheduler: shares one WIDTH-bit down-counter among NUM_REQ requesters.
// A round-robin arbiter picks an owner in IDLE, the owner's interval is captured
// at grant and counted down in RUN, and a one-cycle done pulse is issued in DONE.
// An owner dropping its request mid-count abandons the interval silently.
module timer_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   load_value,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [WIDTH-1:0]           count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [IW-1:0]                   r_owner;
  logic [IW-1:0]                   r_last;
  logic [WIDTH-1:0]                r_count;
  logic [IW-1:0]                   w_win;
  logic                            w_any;
  logic                            w_owner_req;
  logic [NUM_REQ-1:0]              w_owner_oh;
  logic [NUM_REQ-1:0][WIDTH-1:0]   w_loads;

  // Per-requester view of the flat interval bus.
  assign w_loads     = load_value;
  assign w_owner_oh  = NUM_REQ'(1) << r_owner;
  assign w_owner_req = req[r_owner];
  assign count       = r_count;

  // Round-robin pick: scan from the requester after the last owner, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_any && req[idx]) begin
        w_any = 1'b1;
        w_win = IW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: grant on any request, finish at zero, abort when owner lets go.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_RUN;
      S_RUN: begin
        if (!w_owner_req)       w_next = S_IDLE;
        else if (r_count == '0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; done is only ever the owner's grant bit.
  always_comb begin
    grant = '0;
    done  = '0;
    busy  = 1'b0;
    case (r_state)
      S_RUN: begin
        grant = w_owner_oh;
        busy  = 1'b1;
      end
      S_DONE: begin
        grant = w_owner_oh;
        done  = w_owner_oh;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: capture interval and owner at grant, saturating countdown in RUN.
  // The pointer moves to the owner at grant time; abort and completion both
  // leave it there, so the next search starts just past this owner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_owner <= '0;
      r_last  <= IW'(NUM_REQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_count <= w_loads[w_win];
            r_owner <= w_win;
            r_last  <= w_win;
          end
        end
        S_RUN: begin
          if (w_owner_req && r_count != '0) r_count <= r_count - WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: directed cases with literal expectations plus a
// randomized phase, all compared every cycle against a transaction-level model
// that tracks the owner, its captured interval and cycles elapsed since grant.
module tb_timer_scheduler;
  localparam int NR = 4;
  localparam int W  = 4;

  logic              clock;
  logic              reset_n;
  logic [NR-1:0]     req;
  logic [NR*W-1:0]   load_value;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic              busy;
  logic [W-1:0]      count;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  timer_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .load_value(load_value),
    .grant(grant), .done(done), .busy(busy), .count(count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner -1 means idle. Count is interval minus elapsed cycles, floored at 0;
  // done falls exactly interval+1 cycles after grant.
  int            m_owner, m_last, m_L, m_since, m_pick;
  logic [W-1:0]  m_cnt;
  logic [NR-1:0] e_grant, e_done;
  logic          e_busy;

  function automatic int pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++)
      if (r[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  always_comb m_pick = pick(req, m_last);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_owner <= -1; m_last <= NR - 1; m_cnt <= '0; m_since <= 0; m_L <= 0;
    end else if (m_owner < 0) begin
      if (m_pick >= 0) begin
        m_owner <= m_pick;
        m_last  <= m_pick;
        m_L     <= int'(load_value[m_pick*W +: W]);
        m_cnt   <= load_value[m_pick*W +: W];
        m_since <= 0;
      end
    end else if (m_since == m_L + 1) begin
      m_owner <= -1;
    end else if (!req[m_owner]) begin
      m_owner <= -1;
    end else begin
      m_since <= m_since + 1;
      m_cnt   <= (m_since + 1 >= m_L) ? '0 : W'(m_L - m_since - 1);
    end
  end

  always_comb begin
    e_grant = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
    e_busy  = (m_owner >= 0);
    e_done  = (m_owner >= 0 && m_since == m_L + 1) ? e_grant : '0;
  end

  // Every-cycle comparison against the model plus structural invariants.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_grant", 32'(grant), 32'(e_grant));
      chk("m_busy",  32'(busy),  32'(e_busy));
      chk("m_done",  32'(done),  32'(e_done));
      chk("m_count", 32'(count), 32'(m_cnt));
      chk("inv_onehot", 32'($onehot0(grant)), 32'd1);
      chk("inv_done_sub", 32'((done & ~grant) == '0), 32'd1);
      chk("inv_busy", 32'(busy), 32'(|grant));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    req = '0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    req = '0;
    load_value = '0;
    do_reset();

    // Single request, interval 3: counts 3,2,1,0 then done.
    req = 4'b0001; load_value = 16'h0003;
    tick(); chk("a_grant", 32'(grant), 32'h1); chk("a_cnt3", 32'(count), 32'd3);
    tick(); chk("a_cnt2", 32'(count), 32'd2);
    tick(); chk("a_cnt1", 32'(count), 32'd1);
    tick(); chk("a_cnt0", 32'(count), 32'd0); chk("a_nodone", 32'(done), 32'd0);
    tick(); chk("a_done", 32'(done), 32'h1);
    req = '0;
    tick(); chk("a_idle_grant", 32'(grant), 32'd0); chk("a_idle_busy", 32'(busy), 32'd0);

    // Zero interval on requester 2.
    req = 4'b0100; load_value = 16'h0000;
    tick(); chk("b_grant", 32'(grant), 32'h4); chk("b_cnt", 32'(count), 32'd0);
    tick(); chk("b_done", 32'(done), 32'h4);
    req = '0;
    tick(); chk("b_idle", 32'(grant), 32'd0);

    // Fairness: all requesting, interval 1 -> 3 cycles owned, 1 idle, order 0,1,2,3,0.
    do_reset();
    req = 4'b1111; load_value = 16'h1111;
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("c_grant", 32'(grant), (t % 4 == 3) ? 32'd0 : 32'(1 << ((t / 4) % 4)));
      chk("c_done",  32'(done),  (t % 4 == 2) ? 32'(1 << ((t / 4) % 4)) : 32'd0);
    end
    req = '0;
    tick(); tick(); tick(); tick();

    // Abort: requester 1 drops at count 2; next pick with 0011 wraps to 0.
    do_reset();
    req = 4'b0010; load_value = 16'h0051;
    tick(); chk("d_grant", 32'(grant), 32'h2); chk("d_cnt5", 32'(count), 32'd5);
    tick(); tick();
    tick(); chk("d_cnt2", 32'(count), 32'd2);
    req = '0;
    tick(); chk("d_ab_grant", 32'(grant), 32'd0); chk("d_ab_done", 32'(done), 32'd0);
    chk("d_ab_cnt", 32'(count), 32'd2); chk("d_ab_busy", 32'(busy), 32'd0);
    req = 4'b0011;
    tick(); chk("d_wrap", 32'(grant), 32'h1); chk("d_wrap_cnt", 32'(count), 32'd1);
    req = '0;
    tick(); tick();

    // Async reset in the middle of a count of 8, caught at 5.
    do_reset();
    req = 4'b0001; load_value = 16'h0008;
    tick(); tick(); tick();
    tick(); chk("e_cnt5", 32'(count), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("e_grant", 32'(grant), 32'd0); chk("e_busy", 32'(busy), 32'd0);
    chk("e_count", 32'(count), 32'd0); chk("e_done", 32'(done), 32'd0);
    #1 reset_n = 1'b1;
    req = 4'b1000; load_value = 16'h3000;
    tick(); chk("e_regrant", 32'(grant), 32'h8); chk("e_cnt3", 32'(count), 32'd3);
    req = '0;
    tick(); tick();

    // Load capture: interval 7 captured, later change to 2 ignored.
    do_reset();
    req = 4'b0001; load_value = 16'h0007;
    tick(); chk("f_grant", 32'(grant), 32'h1); chk("f_cnt7", 32'(count), 32'd7);
    load_value = 16'h0002;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i <= 7) chk("f_cnt", 32'(count), 32'(7 - i));
      chk("f_done", 32'(done), (i == 8) ? 32'h1 : 32'd0);
    end
    req = '0;
    tick(); tick();

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 500; c++) begin
      tick();
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(0, 4) == 0) req[b] = ~req[b];
        load_value[b*W +: W] = W'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 149) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end
    req = '0;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
